// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Sequential successor of a word address; wraps 32'hFFFF_FFFC -> 32'h0.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter: loads RESET_PC on reset, takes redirects, advances on capture.
module fetch_pc_register
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    input  logic [31:0] fetch_addr,
    output logic [31:0] pc
);

    // Redirect outranks sequential advance; redirect target is forced word-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'h0000_0003;
        end else if (advance) begin
            pc <= next_word(fetch_addr);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: drives the instruction-memory handshake and feeds the IF/ID register.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_4,
    output logic        valid,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc4;
    logic         out_valid;
    logic         fetch_req;
    logic         consume;
    logic         capture;

    fetch_pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .advance       (capture),
        .fetch_addr    (imem_addr),
        .pc            (pc)
    );

    // Request and address: IDLE issues from pc unless an unconsumed output is stalled.
    always_comb begin
        fetch_req = 1'b1;
        imem_addr = req_addr;
        if (state == IDLE) begin
            fetch_req = !(out_valid && stall);
            imem_addr = pc;
        end
    end

    assign imem_req    = reset && fetch_req;
    assign consume     = out_valid && !stall;
    assign capture     = fetch_req && imem_ready && (state != DISCARD) && !redirect_valid;
    assign instruction = out_valid ? out_instr : NOP_INSTR;
    assign pc_plus_4   = out_pc4;
    assign valid       = out_valid;

    // Fetch FSM with registered IF/ID outputs and delivered-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_addr    <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_pc4     <= '0;
            fetch_count <= '0;
        end else begin
            if (capture) begin
                out_valid   <= 1'b1;
                out_instr   <= imem_rdata;
                out_pc4     <= next_word(imem_addr);
                fetch_count <= fetch_count + 32'd1;
            end else if (redirect_valid || consume) begin
                out_valid <= 1'b0;
            end
            // A request that completes in the redirect cycle needs no DISCARD pass.
            case (state)
                IDLE: begin
                    if (fetch_req && !imem_ready) begin
                        req_addr <= pc;
                        state    <= redirect_valid ? DISCARD : BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ready) begin
                        state <= IDLE;
                    end else if (redirect_valid) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: scoreboard monitor plus directed sequences.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] pc_plus_4;
    logic        valid;
    logic [31:0] fetch_count;

    int unsigned total = 0;
    int unsigned bad = 0;

    // Memory model: returns address as data, except one planted load word.
    int unsigned wait_states = 0;
    int unsigned wcnt;
    localparam logic [31:0] SPECIAL_ADDR  = 32'h0040_0008;
    localparam logic [31:0] SPECIAL_INSTR = 32'h8C08_0004;

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC(32'h0040_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instruction   (instruction),
        .pc_plus_4     (pc_plus_4),
        .valid         (valid),
        .fetch_count   (fetch_count)
    );

    assign imem_ready = imem_req && (wcnt >= wait_states);
    assign imem_rdata = !imem_ready ? 32'hDEAD_BEEF :
                        (imem_addr == SPECIAL_ADDR) ? SPECIAL_INSTR : imem_addr;

    // Wait-state counter of the memory model.
    always @(posedge clk or negedge reset) begin
        if (!reset) wcnt <= 0;
        else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted fetches are pushed, popped when the DUT presents them.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid = 1'b0;
    logic        m_discard = 1'b0;
    logic        got_new = 1'b0;
    logic [31:0] m_count = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc4 = '0;

    // Monitor samples on the falling edge, checks, then advances its own model.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            sb.delete();
            m_valid   = 1'b0;
            m_discard = 1'b0;
            got_new   = 1'b0;
            m_count   = '0;
            chk("rst_req",   32'(imem_req), 32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_instr", instruction, 32'd0);
            chk("rst_pc4",   pc_plus_4, 32'd0);
            chk("rst_count", fetch_count, 32'd0);
        end else begin
            if (got_new) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got empty queue expected an entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    m_instr = e.instr;
                    m_pc4   = e.pc4;
                end
            end
            chk("mon_valid", 32'(valid), 32'(m_valid));
            chk("mon_count", fetch_count, m_count);
            if (m_valid) begin
                chk("mon_instr", instruction, m_instr);
                chk("mon_pc4",   pc_plus_4, m_pc4);
            end else begin
                chk("mon_nop", instruction, 32'd0);
            end
            got_new = 1'b0;
            if (imem_req && imem_ready) begin
                if (!redirect_valid && !m_discard) begin
                    sb.push_back({imem_rdata, imem_addr + 32'd4});
                    got_new = 1'b1;
                    m_count = m_count + 32'd1;
                end
                m_discard = 1'b0;
            end else if (imem_req && redirect_valid) begin
                m_discard = 1'b1;
            end
            if (redirect_valid) m_valid = 1'b0;
            else if (got_new) m_valid = 1'b1;
            else if (!stall) m_valid = 1'b0;
        end
    end

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
    } redir_vec_t;

    redir_vec_t tbl[4];

    initial begin
        logic [31:0] a;
        logic [31:0] cnt;

        tbl[0] = '{32'h1234_567B, 32'h1234_5678, 32'h1234_567C};
        tbl[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
        tbl[3] = '{32'h0040_0206, 32'h0040_0204, 32'h0040_0208};

        // Reset release with zero-wait memory.
        repeat (2) step();
        reset = 1'b1;
        #1;
        chk("s1_addr0", imem_addr, 32'h0040_0000);
        chk("s1_req0",  32'(imem_req), 32'd1);
        step();
        chk("s1_addr1",  imem_addr, 32'h0040_0004);
        chk("s1_valid1", 32'(valid), 32'd1);
        chk("s1_instr1", instruction, 32'h0040_0000);
        step();
        chk("s1_addr2", imem_addr, 32'h0040_0008);
        step();
        chk("s1_count3", fetch_count, 32'd3);

        // Stall for 3 cycles holding the load word.
        stall = 1'b1;
        #1;
        chk("st_instr", instruction, SPECIAL_INSTR);
        chk("st_pc4",   pc_plus_4, 32'h0040_000C);
        chk("st_req",   32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_req",   32'(imem_req), 32'd0);
            chk("st_hold_valid", 32'(valid), 32'd1);
            chk("st_hold_instr", instruction, SPECIAL_INSTR);
            chk("st_hold_pc4",   pc_plus_4, 32'h0040_000C);
            chk("st_hold_count", fetch_count, 32'd3);
        end
        stall = 1'b0;
        #1;
        chk("st_resume_addr", imem_addr, 32'h0040_000C);
        chk("st_resume_req",  32'(imem_req), 32'd1);
        step();
        chk("st_resume_instr", instruction, 32'h0040_000C);
        chk("st_resume_count", fetch_count, 32'd4);

        // Two wait states: address held, one instruction every 3 cycles.
        wait_states = 2;
        #1;
        a = 32'h0040_0010;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                chk("ws_addr", imem_addr, a);
                chk("ws_req",  32'(imem_req), 32'd1);
                chk("ws_ready", 32'(imem_ready), (c == 2) ? 32'd1 : 32'd0);
                if (c == 1) chk("ws_gap_valid", 32'(valid), 32'd0);
                step();
            end
            chk("ws_valid", 32'(valid), 32'd1);
            chk("ws_instr", instruction, a);
            a = a + 32'd4;
        end
        chk("ws_count", fetch_count, 32'd6);

        // Redirect while BUSY: outstanding word dropped, refetch at aligned target.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        #1;
        chk("rb_busy_ready", 32'(imem_ready), 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rb_disc_addr",  imem_addr, 32'h0040_0018);
        chk("rb_disc_valid", 32'(valid), 32'd0);
        chk("rb_disc_ready", 32'(imem_ready), 32'd1);
        step();
        chk("rb_new_addr",  imem_addr, 32'h0040_0100);
        chk("rb_new_valid", 32'(valid), 32'd0);
        chk("rb_new_count", fetch_count, 32'd6);
        repeat (3) step();
        chk("rb_del_valid", 32'(valid), 32'd1);
        chk("rb_del_instr", instruction, 32'h0040_0100);
        chk("rb_del_pc4",   pc_plus_4, 32'h0040_0104);
        chk("rb_del_count", fetch_count, 32'd7);

        // Redirects coincident with zero-wait captures, including adder wrap.
        wait_states = 0;
        cnt = 32'd7;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk("tb_coinc_ready", 32'(imem_ready), 32'd1);
            step();
            redirect_valid = 1'b0;
            #1;
            chk("tb_valid0", 32'(valid), 32'd0);
            chk("tb_addr",   imem_addr, tbl[i].exp_addr);
            chk("tb_count0", fetch_count, cnt);
            step();
            chk("tb_valid1", 32'(valid), 32'd1);
            chk("tb_instr",  instruction, tbl[i].exp_addr);
            chk("tb_pc4",    pc_plus_4, tbl[i].exp_pc4);
            cnt = cnt + 32'd1;
            chk("tb_count1", fetch_count, cnt);
        end

        // Asynchronous reset in the middle of a BUSY request.
        wait_states = 2;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("ar_req",   32'(imem_req), 32'd0);
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_instr", instruction, 32'd0);
        chk("ar_pc4",   pc_plus_4, 32'd0);
        chk("ar_count", fetch_count, 32'd0);
        repeat (2) step();
        reset = 1'b1;
        #1;
        chk("ar_rel_addr",  imem_addr, 32'h0040_0000);
        chk("ar_rel_req",   32'(imem_req), 32'd1);
        chk("ar_rel_valid", 32'(valid), 32'd0);
        repeat (3) step();
        chk("ar_del_valid", 32'(valid), 32'd1);
        chk("ar_del_instr", instruction, 32'h0040_0000);
        chk("ar_del_count", fetch_count, 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
